// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, func opcodes and reservation-station entry layout
// for the Tomasulo issue/execute slice.
package tomasulo_pkg;
   localparam int DATA_W     = 16;
   localparam int TAG_W      = 3;
   localparam int OP_W       = 4;
   localparam int RS_ENTRIES = 3;
   localparam int CNT_W      = 3;

   localparam logic [OP_W-1:0] OP_ADD = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB = 4'd1;
   localparam logic [OP_W-1:0] OP_MUL = 4'd2;
   localparam logic [OP_W-1:0] OP_DIV = 4'd3;
   localparam logic [OP_W-1:0] OP_BEQ = 4'd4;
   localparam logic [OP_W-1:0] OP_BNE = 4'd5;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] vj;
      logic [DATA_W-1:0] vk;
      logic [TAG_W-1:0]  qj;
      logic [TAG_W-1:0]  qk;
      logic              pj;
      logic              pk;
      logic [TAG_W-1:0]  rob_tag;
   } rs_entry_t;
endpackage

// File: rtl/rs_oldest_pick.sv
// rs_oldest_pick: grants the oldest ready entry; i_age[a][b]=1 means entry a is older
// than entry b, and the diagonal is held at zero so a ready entry never blocks itself.
module rs_oldest_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0]        i_ready,
   input  logic [N-1:0][N-1:0] i_age,
   output logic [N-1:0]        o_grant,
   output logic                o_valid
);
   assign o_valid = |i_ready;

   always_comb begin
      o_grant = i_ready;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (i_ready[j] && i_age[j][i]) o_grant[i] = 1'b0;
   end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: one RS bank holding renamed instructions, waking operands from
// the CDB and dispatching the oldest fully-ready entry to its functional unit.
module reservation_station
   import tomasulo_pkg::*;
#(
   parameter int NUM_ENTRIES = RS_ENTRIES
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [OP_W-1:0]   issue_op,
   input  logic [TAG_W-1:0]  issue_rob_tag,
   input  logic [DATA_W-1:0] issue_vj,
   input  logic [DATA_W-1:0] issue_vk,
   input  logic [TAG_W-1:0]  issue_qj,
   input  logic [TAG_W-1:0]  issue_qk,
   input  logic              issue_pj,
   input  logic              issue_pk,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic              disp_valid,
   input  logic              disp_ready,
   output logic [OP_W-1:0]   disp_op,
   output logic [DATA_W-1:0] disp_vj,
   output logic [DATA_W-1:0] disp_vk,
   output logic [TAG_W-1:0]  disp_rob_tag,
   output logic [CNT_W-1:0]  count
);
   logic [NUM_ENTRIES-1:0]                  r_busy;
   rs_entry_t                               r_ent [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_age;
   logic [CNT_W-1:0]                        r_count;

   logic [NUM_ENTRIES-1:0] w_ready, w_grant, w_alloc_oh;
   logic                   w_pick_valid, w_alloc, w_disp, w_hit_j, w_hit_k;
   rs_entry_t              w_new;

   assign issue_ready = r_count < CNT_W'(NUM_ENTRIES);
   assign w_alloc     = issue_valid && issue_ready && !flush;
   assign w_disp      = w_pick_valid && disp_ready && !flush;
   assign w_hit_j     = issue_pj && cdb_valid && issue_qj == cdb_tag;
   assign w_hit_k     = issue_pk && cdb_valid && issue_qk == cdb_tag;
   assign count       = r_count;
   assign disp_valid  = w_pick_valid;

   // Operands broadcast in the issue cycle are captured directly into the new entry.
   assign w_new = '{op:      issue_op,
                    vj:      w_hit_j ? cdb_data : issue_vj,
                    vk:      w_hit_k ? cdb_data : issue_vk,
                    qj:      issue_qj,
                    qk:      issue_qk,
                    pj:      issue_pj && !w_hit_j,
                    pk:      issue_pk && !w_hit_k,
                    rob_tag: issue_rob_tag};

   always_comb begin
      w_ready    = '0;
      w_alloc_oh = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         w_ready[i] = r_busy[i] && !r_ent[i].pj && !r_ent[i].pk;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (!r_busy[i]) begin
            w_alloc_oh    = '0;
            w_alloc_oh[i] = 1'b1;
         end
   end

   rs_oldest_pick #(.N(NUM_ENTRIES)) u_pick (
      .i_ready (w_ready),
      .i_age   (r_age),
      .o_grant (w_grant),
      .o_valid (w_pick_valid)
   );

   always_comb begin
      disp_op      = '0;
      disp_vj      = '0;
      disp_vk      = '0;
      disp_rob_tag = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         if (w_grant[i]) begin
            disp_op      |= r_ent[i].op;
            disp_vj      |= r_ent[i].vj;
            disp_vk      |= r_ent[i].vk;
            disp_rob_tag |= r_ent[i].rob_tag;
         end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_age   <= '0;
         r_count <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i] <= '0;
      end else if (flush) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_disp);
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_disp && w_grant[i]) r_busy[i] <= 1'b0;
            if (r_busy[i] && r_ent[i].pj && cdb_valid && r_ent[i].qj == cdb_tag) begin
               r_ent[i].vj <= cdb_data;
               r_ent[i].pj <= 1'b0;
            end
            if (r_busy[i] && r_ent[i].pk && cdb_valid && r_ent[i].qk == cdb_tag) begin
               r_ent[i].vk <= cdb_data;
               r_ent[i].pk <= 1'b0;
            end
            // A new entry becomes younger than every other slot.
            if (w_alloc && w_alloc_oh[i]) begin
               r_busy[i] <= 1'b1;
               r_ent[i]  <= w_new;
               for (int j = 0; j < NUM_ENTRIES; j++) begin
                  r_age[i][j] <= 1'b0;
                  r_age[j][i] <= (j != i);
               end
            end
         end
      end
   end
endmodule
